// File: rtl/shift_unit_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit_seq_pkg
//  Description : Shared definitions for the iterative shifter. Holds the
//                shift-op encodings, the FSM state encoding and the default
//                operand/amount widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_unit_seq_pkg;

    // Default widths; the amount width must equal clog2 of the data width
    localparam int DEF_DATA_W = 32;
    localparam int DEF_AMT_W  = 5;

    // Shift operation encodings (3-bit op field); 3'b11x behaves as pass
    localparam logic [2:0] SH_NONE = 3'b000;
    localparam logic [2:0] SH_SLL  = 3'b001;
    localparam logic [2:0] SH_SRL  = 3'b010;
    localparam logic [2:0] SH_SRA  = 3'b011;
    localparam logic [2:0] SH_ROL  = 3'b100;
    localparam logic [2:0] SH_ROR  = 3'b101;

    // Control FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : shift_unit_seq_pkg
`default_nettype wire

// File: rtl/shift_unit_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit_seq_if
//  Description : Request/response bundle between the control path and the
//                iterative shifter.
//                  start     : request pulse (master -> slave)
//                  op        : shift operation (master -> slave)
//                  in_data   : operand (master -> slave)
//                  shift_amt : shift amount (master -> slave)
//                  busy      : shifter occupied (slave -> master)
//                  done      : one-cycle completion pulse (slave -> master)
//                  out       : result register (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_unit_seq_if #(
    parameter int DATA_W = shift_unit_seq_pkg::DEF_DATA_W,
    parameter int AMT_W  = shift_unit_seq_pkg::DEF_AMT_W
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] in_data;
    logic [AMT_W-1:0]  shift_amt;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] out;

    modport master (
        output start, op, in_data, shift_amt,
        input  busy, done, out
    );

    modport slave (
        input  start, op, in_data, shift_amt,
        output busy, done, out
    );

endinterface : shift_unit_seq_if
`default_nettype wire

// File: rtl/shift_unit_seq_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit_seq_step
//  Description : Combinational single-bit shift/rotate step.
//                  i_x  : current value
//                  i_op : shift operation
//                  o_y  : value after one bit position of the operation
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_unit_seq_step
    import shift_unit_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic [DATA_W-1:0] i_x,
    input  wire logic [2:0]        i_op,
    output logic      [DATA_W-1:0] o_y
);

    always_comb begin
        o_y = i_x;
        case (i_op)
            SH_SLL:  o_y = {i_x[DATA_W-2:0], 1'b0};
            SH_SRL:  o_y = {1'b0, i_x[DATA_W-1:1]};
            SH_SRA:  o_y = {i_x[DATA_W-1], i_x[DATA_W-1:1]};
            SH_ROL:  o_y = {i_x[DATA_W-2:0], i_x[DATA_W-1]};
            SH_ROR:  o_y = {i_x[0], i_x[DATA_W-1:1]};
            default: o_y = i_x;   // none and 3'b11x pass through
        endcase
    end

endmodule : shift_unit_seq_step
`default_nettype wire

// File: rtl/shift_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit_seq
//  Description : Iterative shifter. Latches operand, amount and op on an
//                accepted start, shifts one bit position per clock, then
//                pulses done for one cycle with the result held in out.
//                  clk   : system clock, rising edge
//                  reset : synchronous, active-low reset
//                  bus   : slave side of shift_unit_seq_if
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_unit_seq
    import shift_unit_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMT_W  = DEF_AMT_W
) (
    input  wire logic       clk,
    input  wire logic       reset,
    shift_unit_seq_if.slave bus
);

    state_t            r_state;
    logic [AMT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_out;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] w_step;

    shift_unit_seq_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_x  (r_out),
        .i_op (r_op),
        .o_y  (w_step)
    );

    // busy/done are registered alongside the state transition so they track
    // the state exactly without any combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= SH_NONE;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= ST_SHIFT;
                        r_out   <= bus.in_data;
                        r_cnt   <= bus.shift_amt;
                        r_op    <= bus.op;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // The final cycle (cnt==0) only moves to DONE, so an
                    // amount of N costs N+1 cycles in SHIFT.
                    if (r_cnt != '0) begin
                        r_out <= w_step;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Any start seen here is dropped, not queued.
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.out  = r_out;

endmodule : shift_unit_seq
`default_nettype wire

// File: tb/tb_shift_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_unit_seq
//  Description : Self-checking bench for shift_unit_seq. The driver pushes
//                the expected result and completion cycle into a scoreboard;
//                a monitor pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_unit_seq;
    import shift_unit_seq_pkg::*;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    shift_unit_seq_if #(.DATA_W(32), .AMT_W(5)) bus ();

    shift_unit_seq #(
        .DATA_W (32),
        .AMT_W  (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the head of the scoreboard in
    // both value and cycle of arrival.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d out=%h, required no done", cyc, bus.out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.out !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result: got out=%h at cycle %0d, required out=%h at cycle %0d",
                             bus.out, cyc, e.val, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns one negedge
    // after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [4:0] amt,
                         input logic [31:0] exp, input bit push);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.in_data   = d;
        bus.shift_amt = amt;
        if (push) sb.push_back('{val: exp, cyc: cyc + int'(amt) + 2});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && bus.busy === 1'b0) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL timeout: got busy=%b pending=%0d, required idle", bus.busy, sb.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        // Reset with a start held high: it must be ignored
        reset         = 1'b0;
        bus.start     = 1'b1;
        bus.op        = SH_SLL;
        bus.in_data   = 32'hFFFF_FFFF;
        bus.shift_amt = 5'd3;
        repeat (2) @(negedge clk);
        chk("reset_out",  bus.out,         32'h0);
        chk("reset_busy", {31'b0, bus.busy}, 32'h0);
        chk("reset_done", {31'b0, bus.done}, 32'h0);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("post_reset_out",  bus.out,           32'h0);
        chk("post_reset_busy", {31'b0, bus.busy}, 32'h0);

        // sll with busy timeline
        issue(SH_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("sll_busy_E%0d", k), {31'b0, bus.busy}, 32'h1);
        end
        @(negedge clk);
        chk("sll_busy_E6", {31'b0, bus.busy}, 32'h0);
        chk("sll_hold",    bus.out,           32'h0000_0010);
        wait_idle();

        issue(SH_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b1); wait_idle();
        issue(SH_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b1); wait_idle();
        issue(SH_ROL, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b1); wait_idle();
        issue(SH_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1); wait_idle();
        issue(SH_SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b1); wait_idle();
        issue(3'b110, 32'h1234_5678, 5'd5,  32'h1234_5678, 1'b1); wait_idle();

        // Inputs changed after acceptance must not disturb the operation
        issue(SH_SLL, 32'h0000_00F0, 5'd4, 32'h0000_0F00, 1'b1);
        bus.op        = SH_ROR;
        bus.in_data   = 32'hFFFF_FFFF;
        bus.shift_amt = 5'd31;
        wait_idle();
        chk("idle_hold", bus.out, 32'h0000_0F00);

        // Start while busy is ignored: exactly one done
        issue(SH_SLL, 32'h0000_0001, 5'd8, 32'h0000_0100, 1'b1);
        repeat (3) @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = SH_ROR;
        bus.in_data   = 32'hAAAA_5555;
        bus.shift_amt = 5'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // Reset mid-SHIFT aborts without a done
        issue(SH_SLL, 32'h0000_0001, 5'd20, 32'h0, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_out",  bus.out,           32'h0);
        chk("abort_busy", {31'b0, bus.busy}, 32'h0);
        chk("abort_done", {31'b0, bus.done}, 32'h0);
        repeat (30) @(negedge clk);
        chk("abort_idle", {31'b0, bus.busy}, 32'h0);

        // Start held from the DONE cycle: dropped there, accepted next cycle
        issue(SH_ROR, 32'h0000_0001, 5'd1, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) break;
            @(negedge clk);
        end
        bus.start     = 1'b1;
        bus.op        = SH_ROL;
        bus.in_data   = 32'h8000_0001;
        bus.shift_amt = 5'd1;
        @(negedge clk);
        sb.push_back('{val: 32'h0000_0003, cyc: cyc + 1 + 2});
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_unit_seq
`default_nettype wire
